// File: rtl/pcie_msi_intr_ctl.sv
// rtl/pcie_msi_intr_ctl.sv - edge-triggered irq lines to PCIe MSI req/ack (optional PCIE_MSI_IRQ_SYNC_EN input synchronizer)
module pcie_msi_intr_ctl #(
    parameter int         NUM_IRQ = 8,
    parameter logic [2:0] MSI_TC  = 3'd0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    output logic               app_msi_req,
    output logic [4:0]         app_msi_num,
    output logic [2:0]         app_msi_tc,
    input  logic               app_msi_ack,
    output logic               app_int_sts,
    input  logic               app_int_ack
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [4:0]         num_q, num_d;
    logic               redo_q, redo_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] served;
    logic [4:0]         sel_idx;
    logic               unused_int_ack;

`ifdef PCIE_MSI_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq;
`endif

    assign rise           = irq_s & ~irq_prev_q;
    assign app_msi_req    = req_q;
    assign app_msi_num    = num_q;
    assign app_msi_tc     = MSI_TC;
    assign app_int_sts    = 1'b0;
    assign unused_int_ack = app_int_ack;

    always_comb begin
        sel_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending_q[i]) sel_idx = 5'(i);
        end
    end

    always_comb begin
        served = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (num_q == 5'(i)) served[i] = 1'b1;
        end
    end

    // Edges on the served line during WAIT are remembered in redo so the
    // ack-time clear does not swallow them; they yield exactly one more MSI.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        num_d     = num_q;
        redo_d    = redo_q;
        pending_d = pending_q | rise;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    req_d   = 1'b1;
                    num_d   = sel_idx;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (|(rise & served)) redo_d = 1'b1;
                if (app_msi_ack) begin
                    req_d     = 1'b0;
                    redo_d    = 1'b0;
                    state_d   = ST_IDLE;
                    pending_d = (pending_q & ~served) | rise | (redo_q ? served : '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            num_q      <= '0;
            redo_q     <= 1'b0;
            pending_q  <= '0;
            irq_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            num_q      <= num_d;
            redo_q     <= redo_d;
            pending_q  <= pending_d;
            irq_prev_q <= irq_s;
        end
    end

endmodule

// File: tb/tb_pcie_msi_intr_ctl.sv
// tb/tb_pcie_msi_intr_ctl.sv - directed vector bench for pcie_msi_intr_ctl
module tb_pcie_msi_intr_ctl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq;
    logic       app_msi_req;
    logic [4:0] app_msi_num;
    logic [2:0] app_msi_tc;
    logic       app_msi_ack;
    logic       app_int_sts;
    logic       app_int_ack;

    int n_checks = 0;
    int n_bad    = 0;

    logic [4:0] req_nums[$];
    logic       req_prev = 1'b0;

    typedef struct {
        logic [7:0] irq;
        logic       ack;
        logic       exp_req;
        logic       chk_num;
        logic [4:0] exp_num;
    } vec_t;

    vec_t tbl[18];

    pcie_msi_intr_ctl #(.NUM_IRQ(8), .MSI_TC(3'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq),
        .app_msi_req (app_msi_req),
        .app_msi_num (app_msi_num),
        .app_msi_tc  (app_msi_tc),
        .app_msi_ack (app_msi_ack),
        .app_int_sts (app_int_sts),
        .app_int_ack (app_int_ack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (app_msi_req && !req_prev) req_nums.push_back(app_msi_num);
        req_prev = app_msi_req;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge: check outputs, then drive inputs for the next posedge.
    task automatic step(input string nm, input logic [7:0] i, input logic a,
                        input logic er, input logic cn, input logic [4:0] en);
        chk({nm, ".req"}, {31'd0, app_msi_req}, {31'd0, er});
        if (cn) chk({nm, ".num"}, {27'd0, app_msi_num}, {27'd0, en});
        irq         = i;
        app_msi_ack = a;
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] exp_nums[9];
        exp_nums = '{5'd3, 5'd2, 5'd7, 5'd5, 5'd5, 5'd0, 5'd0, 5'd4, 5'd4};

        tbl[0]  = '{8'h08, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[1]  = '{8'h00, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[2]  = '{8'h00, 1'b0, 1'b1, 1'b1, 5'd3};
        tbl[3]  = '{8'h00, 1'b0, 1'b1, 1'b1, 5'd3};
        tbl[4]  = '{8'h00, 1'b1, 1'b1, 1'b1, 5'd3};
        tbl[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[6]  = '{8'h00, 1'b1, 1'b0, 1'b0, 5'd0};
        tbl[7]  = '{8'h00, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[8]  = '{8'h84, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[9]  = '{8'h84, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[10] = '{8'h84, 1'b1, 1'b1, 1'b1, 5'd2};
        tbl[11] = '{8'h84, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[12] = '{8'h84, 1'b1, 1'b1, 1'b1, 5'd7};
        tbl[13] = '{8'h00, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[14] = '{8'h00, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[15] = '{8'h00, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[16] = '{8'h00, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[17] = '{8'h00, 1'b0, 1'b0, 1'b0, 5'd0};

        reset       = 1'b1;
        irq         = 8'h00;
        app_msi_ack = 1'b0;
        app_int_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.req", {31'd0, app_msi_req}, 32'd0);
        chk("rst.num", {27'd0, app_msi_num}, 32'd0);
        chk("rst.tc", {29'd0, app_msi_tc}, 32'd0);
        chk("rst.int_sts", {31'd0, app_int_sts}, 32'd0);
        reset = 1'b0;

        for (int k = 0; k < 20; k++) step("idle", 8'h00, 1'b0, 1'b0, 1'b1, 5'd0);
        chk("idle.int_sts", {31'd0, app_int_sts}, 32'd0);

        for (int k = 0; k < 18; k++)
            step($sformatf("tbl%0d", k), tbl[k].irq, tbl[k].ack, tbl[k].exp_req,
                 tbl[k].chk_num, tbl[k].exp_num);

        // irq[5] toggles three times while its request awaits ack
        step("t4a", 8'h20, 1'b0, 1'b0, 1'b0, 5'd0);
        step("t4b", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);
        step("t4c", 8'h20, 1'b0, 1'b1, 1'b1, 5'd5);
        step("t4d", 8'h00, 1'b0, 1'b1, 1'b1, 5'd5);
        step("t4e", 8'h20, 1'b0, 1'b1, 1'b1, 5'd5);
        step("t4f", 8'h00, 1'b0, 1'b1, 1'b1, 5'd5);
        step("t4g", 8'h20, 1'b0, 1'b1, 1'b1, 5'd5);
        step("t4h", 8'h00, 1'b1, 1'b1, 1'b1, 5'd5);
        step("t4i", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);
        step("t4j", 8'h00, 1'b1, 1'b1, 1'b1, 5'd5);
        for (int k = 0; k < 5; k++) step("t4k", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);

        // irq[0] rises in the same cycle its ack is sampled
        step("t5a", 8'h01, 1'b0, 1'b0, 1'b0, 5'd0);
        step("t5b", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);
        step("t5c", 8'h01, 1'b1, 1'b1, 1'b1, 5'd0);
        step("t5d", 8'h01, 1'b0, 1'b0, 1'b0, 5'd0);
        step("t5e", 8'h00, 1'b1, 1'b1, 1'b1, 5'd0);
        for (int k = 0; k < 4; k++) step("t5f", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);

        // reset mid-transaction with 8'hF0 pending
        step("t6a", 8'hF0, 1'b0, 1'b0, 1'b0, 5'd0);
        step("t6b", 8'hF0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("t6c.req", {31'd0, app_msi_req}, 32'd1);
        chk("t6c.num", {27'd0, app_msi_num}, 32'd4);
        reset = 1'b1;
        irq   = 8'h00;
        @(negedge clk);
        chk("t6d.req", {31'd0, app_msi_req}, 32'd0);
        chk("t6d.num", {27'd0, app_msi_num}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) step("t6e", 8'h00, 1'b0, 1'b0, 1'b1, 5'd0);
        step("t6f", 8'h10, 1'b0, 1'b0, 1'b0, 5'd0);
        step("t6g", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);
        step("t6h", 8'h00, 1'b1, 1'b1, 1'b1, 5'd4);
        for (int k = 0; k < 3; k++) step("t6i", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);

        chk("req_count", req_nums.size(), 32'd9);
        for (int k = 0; k < 9; k++) begin
            if (k < req_nums.size())
                chk($sformatf("req_seq%0d", k), {27'd0, req_nums[k]}, {27'd0, exp_nums[k]});
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
